// File: rtl/gvc_pkg.sv
`default_nettype none
// ============================================================================
// gvc_pkg : shared types and helpers for golden_vector_checker
// Revision: 1.0
// ============================================================================
package gvc_pkg;

    localparam int GVC_IN_W  = 60;
    localparam int GVC_OUT_W = 26;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_SETTLE  = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } gvc_state_e;

    // Reference layout at the default widths; the checker rebuilds it at its own widths.
    typedef struct packed {
        logic [GVC_IN_W-1:0]  stim;
        logic [GVC_OUT_W-1:0] gold;
        logic [GVC_OUT_W-1:0] mask;
    } gvc_vec_t;

    function automatic int gvc_vec_w(input int in_w, input int out_w);
        return in_w + 2 * out_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gvc_if.sv
`default_nettype none
// ============================================================================
// gvc_load_if : valid/ready vector-load channel into golden_vector_checker
// Revision: 1.0
// ============================================================================
interface gvc_load_if
    import gvc_pkg::*;
#(
    parameter int IN_W  = GVC_IN_W,
    parameter int OUT_W = GVC_OUT_W
) ();
    logic             valid;
    logic             ready;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] gold;
    logic [OUT_W-1:0] mask;

    modport master (output valid, output stim, output gold, output mask, input  ready);
    modport slave  (input  valid, input  stim, input  gold, input  mask, output ready);
endinterface
`default_nettype wire

// File: rtl/gvc_vector_mem.sv
`default_nettype none
// ============================================================================
// gvc_vector_mem : DEPTH-entry vector store, append-only write, indexed read
// Revision: 1.0
// ============================================================================
module gvc_vector_mem
    import gvc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 4,
    parameter int VEC_W = 112
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr_i,
    input  wire logic             we_i,
    input  wire logic [VEC_W-1:0] wdata_i,
    input  wire logic [IDX_W-1:0] raddr_i,
    output logic      [VEC_W-1:0] rdata_o,
    output logic      [IDX_W-1:0] count_o
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [VEC_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] count_q;

    // Storage is never reset; only the fill count decides which slots are live.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[count_q[ADDR_W-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= '0;
        end else if (we_i) begin
            count_q <= count_q + IDX_W'(1);
        end
    end

    assign rdata_o = (raddr_i < IDX_W'(DEPTH)) ? mem_q[raddr_i[ADDR_W-1:0]] : '0;
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/golden_vector_checker.sv
`default_nettype none
// ============================================================================
// golden_vector_checker : applies stored stimuli to a DUT, compares masked
// responses against golden data and keeps pass/fail statistics.
// Revision: 1.0
// ============================================================================
module golden_vector_checker
    import gvc_pkg::*;
#(
    parameter int IN_W   = GVC_IN_W,
    parameter int OUT_W  = GVC_OUT_W,
    parameter int DEPTH  = 8,
    parameter int SETTLE = 1,
    parameter int IDX_W  = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    gvc_load_if.slave             load,
    input  wire logic             clear_i,
    input  wire logic             start_i,
    output logic      [IN_W-1:0]  dut_in_o,
    input  wire logic [OUT_W-1:0] dut_out_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  res_valid_o,
    output logic      [IDX_W-1:0] res_idx_o,
    output logic                  res_pass_o,
    output logic      [IDX_W-1:0] num_vec_o,
    output logic      [IDX_W-1:0] pass_cnt_o,
    output logic      [IDX_W-1:0] fail_cnt_o,
    output logic                  all_pass_o,
    output logic      [IDX_W-1:0] first_fail_idx_o,
    output logic      [OUT_W-1:0] first_fail_diff_o
);
    localparam int VEC_W = gvc_vec_w(IN_W, OUT_W);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef struct packed {
        logic [IN_W-1:0]  stim;
        logic [OUT_W-1:0] gold;
        logic [OUT_W-1:0] mask;
    } vec_t;

    gvc_state_e       state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [IN_W-1:0]  dut_in_q, dut_in_d;
    logic [OUT_W-1:0] gold_q, gold_d, mask_q, mask_d;
    logic             res_valid_q, res_valid_d, res_pass_q, res_pass_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d;
    logic [IDX_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
    logic [OUT_W-1:0] ff_diff_q, ff_diff_d;

    logic [IDX_W-1:0] w_num_vec, w_raddr;
    logic [VEC_W-1:0] w_rdata;
    vec_t             w_rd, w_wr;
    logic             w_ready, w_load_fire, w_mem_clr, w_fail;
    logic [OUT_W-1:0] w_diff;

    assign w_ready     = (state_q == S_IDLE) && (w_num_vec < IDX_W'(DEPTH));
    assign w_load_fire = load.valid && w_ready;
    assign load.ready  = w_ready;
    assign w_wr.stim   = load.stim;
    assign w_wr.gold   = load.gold;
    assign w_wr.mask   = load.mask;
    assign w_rd        = w_rdata;

    // The single read port always looks at the next vector to apply, so its
    // gold/mask are latched alongside dut_in for use in COMPARE.
    assign w_raddr = (state_q == S_COMPARE) ? k_q + IDX_W'(1) : '0;

    assign w_diff = (dut_out_i ^ gold_q) & mask_q;
    assign w_fail = |w_diff;

    gvc_vector_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .VEC_W (VEC_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (w_mem_clr),
        .we_i    (w_load_fire),
        .wdata_i (w_wr),
        .raddr_i (w_raddr),
        .rdata_o (w_rdata),
        .count_o (w_num_vec)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        settle_d    = settle_q;
        dut_in_d    = dut_in_q;
        gold_d      = gold_q;
        mask_d      = mask_q;
        res_valid_d = 1'b0;
        res_idx_d   = res_idx_q;
        res_pass_d  = res_pass_q;
        pass_cnt_d  = pass_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        ff_idx_d    = ff_idx_q;
        ff_diff_d   = ff_diff_q;
        w_mem_clr   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (clear_i) begin
                    w_mem_clr  = 1'b1;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    ff_idx_d   = '0;
                    ff_diff_d  = '0;
                    state_d    = S_IDLE;
                end else if (start_i && !w_load_fire) begin
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    ff_idx_d   = '0;
                    ff_diff_d  = '0;
                    k_d        = '0;
                    if (w_num_vec == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_APPLY;
                        dut_in_d = w_rd.stim;
                        gold_d   = w_rd.gold;
                        mask_d   = w_rd.mask;
                    end
                end
            end
            S_APPLY: begin
                settle_d = '0;
                state_d  = (SETTLE > 0) ? S_SETTLE : S_COMPARE;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_COMPARE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_COMPARE: begin
                res_valid_d = 1'b1;
                res_idx_d   = k_q;
                res_pass_d  = ~w_fail;
                if (w_fail) begin
                    fail_cnt_d = fail_cnt_q + IDX_W'(1);
                    if (fail_cnt_q == '0) begin
                        ff_idx_d  = k_q;
                        ff_diff_d = w_diff;
                    end
                end else begin
                    pass_cnt_d = pass_cnt_q + IDX_W'(1);
                end
                if (k_q == w_num_vec - IDX_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    k_d      = k_q + IDX_W'(1);
                    dut_in_d = w_rd.stim;
                    gold_d   = w_rd.gold;
                    mask_d   = w_rd.mask;
                    state_d  = S_APPLY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            settle_q    <= '0;
            dut_in_q    <= '0;
            gold_q      <= '0;
            mask_q      <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_pass_q  <= 1'b0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            ff_idx_q    <= '0;
            ff_diff_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            settle_q    <= settle_d;
            dut_in_q    <= dut_in_d;
            gold_q      <= gold_d;
            mask_q      <= mask_d;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
            res_pass_q  <= res_pass_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            ff_idx_q    <= ff_idx_d;
            ff_diff_q   <= ff_diff_d;
        end
    end

    assign dut_in_o          = dut_in_q;
    assign busy_o            = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_COMPARE);
    assign done_o            = (state_q == S_DONE);
    assign res_valid_o       = res_valid_q;
    assign res_idx_o         = res_idx_q;
    assign res_pass_o        = res_pass_q;
    assign num_vec_o         = w_num_vec;
    assign pass_cnt_o        = pass_cnt_q;
    assign fail_cnt_o        = fail_cnt_q;
    assign all_pass_o        = done_o && (fail_cnt_q == '0) && (w_num_vec != '0);
    assign first_fail_idx_o  = ff_idx_q;
    assign first_fail_diff_o = ff_diff_q;

endmodule
`default_nettype wire

// File: tb/tb_golden_vector_checker.sv
`default_nettype none
// ============================================================================
// tb_golden_vector_checker : vector tables plus scoreboard for golden_vector_checker
// Revision: 1.0
// ============================================================================
module tb_golden_vector_checker;
    localparam int IN_W  = 60;
    localparam int OUT_W = 26;
    localparam int DEPTH = 8;
    localparam int IDX_W = 4;

    typedef struct packed {
        logic [IN_W-1:0]  stim;
        logic [OUT_W-1:0] gold;
        logic [OUT_W-1:0] mask;
        logic             exp_pass;
    } vec_rec_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pass;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    sb_t      sb[$];
    vec_rec_t tbl [3][5];
    vec_rec_t cur [DEPTH];

    // Instance A: SETTLE=1 with a passthrough DUT
    gvc_load_if #(.IN_W(IN_W), .OUT_W(OUT_W)) a_if ();
    logic a_clear = 1'b0, a_start = 1'b0;
    logic [IN_W-1:0]  a_dut_in;
    logic [OUT_W-1:0] a_dut_out, a_ffd;
    logic a_busy, a_done, a_rv, a_rp, a_ap;
    logic [IDX_W-1:0] a_ridx, a_nv, a_pc, a_fc, a_ffi;
    assign a_dut_out = a_dut_in[OUT_W-1:0];

    golden_vector_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(1), .IDX_W(IDX_W)) u_dut_a (
        .clk(clk), .rst(rst), .load(a_if), .clear_i(a_clear), .start_i(a_start),
        .dut_in_o(a_dut_in), .dut_out_i(a_dut_out), .busy_o(a_busy), .done_o(a_done),
        .res_valid_o(a_rv), .res_idx_o(a_ridx), .res_pass_o(a_rp), .num_vec_o(a_nv),
        .pass_cnt_o(a_pc), .fail_cnt_o(a_fc), .all_pass_o(a_ap),
        .first_fail_idx_o(a_ffi), .first_fail_diff_o(a_ffd));

    // Instances B (SETTLE=0) and C (SETTLE=3), each feeding a DUT with two cycles of delay
    gvc_load_if #(.IN_W(IN_W), .OUT_W(OUT_W)) b_if ();
    gvc_load_if #(.IN_W(IN_W), .OUT_W(OUT_W)) c_if ();
    logic bc_valid = 1'b0, bc_start = 1'b0, bc_clear = 1'b0;
    logic [IN_W-1:0]  bc_stim = '0;
    logic [OUT_W-1:0] bc_gold = '0, bc_mask = '0;
    assign b_if.valid = bc_valid;  assign c_if.valid = bc_valid;
    assign b_if.stim  = bc_stim;   assign c_if.stim  = bc_stim;
    assign b_if.gold  = bc_gold;   assign c_if.gold  = bc_gold;
    assign b_if.mask  = bc_mask;   assign c_if.mask  = bc_mask;

    logic [IN_W-1:0]  b_dut_in, c_dut_in;
    logic [OUT_W-1:0] b_d1, b_d2, c_d1, c_d2, b_ffd, c_ffd;
    logic b_busy, b_done, b_rv, b_rp, b_ap, c_busy, c_done, c_rv, c_rp, c_ap;
    logic [IDX_W-1:0] b_ridx, b_nv, b_pc, b_fc, b_ffi, c_ridx, c_nv, c_pc, c_fc, c_ffi;

    always @(posedge clk) begin
        if (rst) begin
            b_d1 <= '0; b_d2 <= '0; c_d1 <= '0; c_d2 <= '0;
        end else begin
            b_d1 <= b_dut_in[OUT_W-1:0]; b_d2 <= b_d1;
            c_d1 <= c_dut_in[OUT_W-1:0]; c_d2 <= c_d1;
        end
    end

    golden_vector_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(0), .IDX_W(IDX_W)) u_dut_b (
        .clk(clk), .rst(rst), .load(b_if), .clear_i(bc_clear), .start_i(bc_start),
        .dut_in_o(b_dut_in), .dut_out_i(b_d2), .busy_o(b_busy), .done_o(b_done),
        .res_valid_o(b_rv), .res_idx_o(b_ridx), .res_pass_o(b_rp), .num_vec_o(b_nv),
        .pass_cnt_o(b_pc), .fail_cnt_o(b_fc), .all_pass_o(b_ap),
        .first_fail_idx_o(b_ffi), .first_fail_diff_o(b_ffd));

    golden_vector_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(3), .IDX_W(IDX_W)) u_dut_c (
        .clk(clk), .rst(rst), .load(c_if), .clear_i(bc_clear), .start_i(bc_start),
        .dut_in_o(c_dut_in), .dut_out_i(c_d2), .busy_o(c_busy), .done_o(c_done),
        .res_valid_o(c_rv), .res_idx_o(c_ridx), .res_pass_o(c_rp), .num_vec_o(c_nv),
        .pass_cnt_o(c_pc), .fail_cnt_o(c_fc), .all_pass_o(c_ap),
        .first_fail_idx_o(c_ffi), .first_fail_diff_o(c_ffd));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_rec_t mkvec(input int k);
        logic [63:0] h;
        h = 64'h9E37_79B9_7F4A_7C15 * 64'(k + 1);
        mkvec.stim     = h[IN_W-1:0];
        mkvec.gold     = h[OUT_W-1:0];
        mkvec.mask     = '1;
        mkvec.exp_pass = 1'b1;
    endfunction

    // Scoreboard: every result pulse of instance A must match the oldest expectation
    always @(negedge clk) begin
        if (a_rv) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_unexpected: idx %0d pass %0d with empty scoreboard", a_ridx, a_rp);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("res_idx", 64'(a_ridx), 64'(e.idx));
                chk("res_pass", 64'(a_rp), 64'(e.pass));
            end
        end
    end

    task automatic load_a(input vec_rec_t v);
        int n;
        n = 0;
        a_if.valid = 1'b1; a_if.stim = v.stim; a_if.gold = v.gold; a_if.mask = v.mask;
        while (!a_if.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("load_ready_timeout", 64'(a_if.ready), 64'd1);
        @(negedge clk);
        a_if.valid = 1'b0;
    endtask

    task automatic load_bc(input vec_rec_t v);
        int n;
        n = 0;
        bc_valid = 1'b1; bc_stim = v.stim; bc_gold = v.gold; bc_mask = v.mask;
        while (!(b_if.ready && c_if.ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("load_bc_timeout", 64'(b_if.ready & c_if.ready), 64'd1);
        @(negedge clk);
        bc_valid = 1'b0;
    endtask

    // Start a run on A, count cycles from the start edge to the done edge.
    task automatic run_a(input int n_vec, input int exp_cyc, input bit poke);
        int cyc;
        for (int k = 0; k < n_vec; k++) sb.push_back('{idx: IDX_W'(k), pass: cur[k].exp_pass});
        cyc = 0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (poke && cyc == 5) begin
                chk("busy_midrun", 64'(a_busy), 64'd1);
                chk("ready_midrun", 64'(a_if.ready), 64'd0);
                a_start = 1'b1;
                a_if.valid = 1'b1;
            end
            if (poke && cyc == 6) begin
                a_start = 1'b0;
                a_if.valid = 1'b0;
            end
        end while (!a_done && cyc < exp_cyc + 40);
        a_start = 1'b0;
        a_if.valid = 1'b0;
        chk("run_cycles", 64'(cyc), 64'(exp_cyc));
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("done_held", 64'(a_done), 64'd1);
    endtask

    task automatic check_reset_a(input string t);
        chk({t, "_dut_in"}, 64'(a_dut_in), 64'd0);
        chk({t, "_busy"}, 64'(a_busy), 64'd0);
        chk({t, "_done"}, 64'(a_done), 64'd0);
        chk({t, "_res_valid"}, 64'(a_rv), 64'd0);
        chk({t, "_res_idx_pass"}, 64'({a_ridx, a_rp}), 64'd0);
        chk({t, "_num_vec"}, 64'(a_nv), 64'd0);
        chk({t, "_counts"}, 64'({a_pc, a_fc}), 64'd0);
        chk({t, "_first_fail"}, 64'({a_ffi, a_ffd}), 64'd0);
        chk({t, "_all_pass"}, 64'(a_ap), 64'd0);
        chk({t, "_load_ready"}, 64'(a_if.ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int np, nf, cb, cc, cyc;
        vec_rec_t v0;

        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 5; k++) tbl[c][k] = mkvec(k);
        tbl[1][2].gold     = tbl[1][2].gold ^ 26'h8;
        tbl[1][2].exp_pass = 1'b0;
        tbl[2][2].gold     = tbl[2][2].gold ^ 26'h8;
        tbl[2][2].mask     = ~26'h8;
        tbl[2][4].gold     = ~tbl[2][4].gold;
        tbl[2][4].mask     = '0;

        a_if.valid = 1'b0; a_if.stim = '0; a_if.gold = '0; a_if.mask = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_a("reset");
        rst = 1'b0;

        // Five-vector runs: all pass, one gold mismatch, same mismatch masked off
        for (int c = 0; c < 3; c++) begin
            a_clear = 1'b1;
            @(negedge clk);
            a_clear = 1'b0;
            for (int k = 0; k < 5; k++) begin
                load_a(tbl[c][k]);
                cur[k] = tbl[c][k];
            end
            chk("num_vec5", 64'(a_nv), 64'd5);
            run_a(5, 15, 1'b0);
            np = 0;
            for (int k = 0; k < 5; k++) np += int'(tbl[c][k].exp_pass);
            nf = 5 - np;
            chk("pass_cnt", 64'(a_pc), 64'(np));
            chk("fail_cnt", 64'(a_fc), 64'(nf));
            chk("all_pass", 64'(a_ap), 64'(nf == 0));
            if (c == 1) begin
                chk("first_fail_idx", 64'(a_ffi), 64'd2);
                chk("first_fail_diff", 64'(a_ffd), 64'h8);
            end
        end

        // Fill to DEPTH, offer a ninth vector, then run with start/load pokes mid-run
        a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
        chk("clear_done", 64'(a_done), 64'd0);
        chk("clear_num_vec", 64'(a_nv), 64'd0);
        for (int k = 0; k < DEPTH; k++) begin
            cur[k] = mkvec(k + 10);
            load_a(cur[k]);
        end
        chk("full_ready", 64'(a_if.ready), 64'd0);
        chk("full_num_vec", 64'(a_nv), 64'd8);
        a_if.valid = 1'b1; a_if.stim = mkvec(30).stim;
        repeat (3) @(negedge clk);
        a_if.valid = 1'b0;
        chk("ninth_rejected", 64'(a_nv), 64'd8);
        run_a(DEPTH, 24, 1'b1);
        chk("full_pass_cnt", 64'(a_pc), 64'd8);
        chk("full_fail_cnt", 64'(a_fc), 64'd0);
        chk("full_num_vec_after", 64'(a_nv), 64'd8);

        // Reset during SETTLE of vector 1: only vector 0 may report
        sb.push_back('{idx: IDX_W'(0), pass: 1'b1});
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_rst", 64'(a_busy), 64'd1);
        chk("dut_in_vec1", 64'(a_dut_in), 64'(cur[1].stim));
        rst = 1'b1;
        @(negedge clk);
        check_reset_a("midrun_rst");
        chk("midrun_sb", 64'(sb.size()), 64'd0);
        rst = 1'b0;

        // Start with nothing stored
        a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("empty_done", 64'(a_done), 64'd1);
        chk("empty_all_pass", 64'(a_ap), 64'd0);
        chk("empty_counts", 64'({a_pc, a_fc}), 64'd0);

        // SETTLE=0 vs SETTLE=3 against a two-cycle-delayed DUT
        for (int k = 0; k < 4; k++) load_bc(mkvec(k));
        chk("bc_num_vec", 64'({b_nv, c_nv}), 64'h44);
        cb = 0; cc = 0; cyc = 0;
        bc_start = 1'b1;
        @(negedge clk);
        bc_start = 1'b0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (b_done && cb == 0) cb = cyc;
            if (c_done && cc == 0) cc = cyc;
        end while ((cb == 0 || cc == 0) && cyc < 60);
        chk("settle0_cycles", 64'(cb), 64'd8);
        chk("settle3_cycles", 64'(cc), 64'd20);
        v0 = mkvec(0);
        chk("settle0_fail_cnt", 64'(b_fc), 64'd4);
        chk("settle0_pass_cnt", 64'(b_pc), 64'd0);
        chk("settle0_first_fail", 64'({b_ffi, b_ffd}), 64'({4'd0, v0.gold}));
        chk("settle0_all_pass", 64'(b_ap), 64'd0);
        chk("settle3_pass_cnt", 64'(c_pc), 64'd4);
        chk("settle3_fail_cnt", 64'(c_fc), 64'd0);
        chk("settle3_all_pass", 64'(c_ap), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
